// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared sizing constants, types and the pointer wrap helper
// for the stream-to-SRAM FIFO controller.
package sram_fifo_pkg;

  localparam int DEPTH     = 384;
  localparam int WIDTH     = 128;
  localparam int ADDR_BITS = 9;
  localparam int CNT_BITS  = ADDR_BITS + 1;

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [CNT_BITS-1:0]  cnt_t;

  // Which SRAM access (if any) owns the single RW port this cycle.
  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_READ  = 2'd2
  } acc_e;

  // Pointer increment that wraps at DEPTH-1, which need not be a power of two.
  function automatic addr_t wrap_inc(input addr_t p);
    addr_t r;
    if (p == addr_t'(DEPTH - 1)) begin
      r = '0;
    end else begin
      r = p + addr_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_fifo_if.sv
// sram_fifo_if: upstream and downstream valid/ready streams of the FIFO.
interface sram_fifo_if;
  import sram_fifo_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sram_fifo_outbuf.sv
// sram_fifo_outbuf: 2-entry output buffer that absorbs the SRAM read latency.
// Entry 0 is always the head; a same-cycle push and pop are both honoured.
module sram_fifo_outbuf
  import sram_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] ent0_r;
  logic [WIDTH-1:0] ent1_r;
  logic [1:0]       cnt_r;

  // Shift/append the two entries according to push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_r <= '0;
      ent1_r <= '0;
      cnt_r  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            ent0_r <= push_data;
            cnt_r  <= 2'd1;
          end else if (cnt_r == 2'd1) begin
            ent1_r <= push_data;
            cnt_r  <= 2'd2;
          end else begin
            cnt_r  <= cnt_r;
          end
        end
        2'b01: begin
          ent0_r <= ent1_r;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            ent0_r <= push_data;
          end else begin
            ent0_r <= ent1_r;
            ent1_r <= push_data;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign cnt  = cnt_r;
  assign head = ent0_r;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: stream-to-SRAM FIFO in front of a single-port 384x128 SRAM.
// Arbitrates the RW port between writes and reads (alternating under
// contention) and hides the 1-cycle read latency with a 2-entry buffer.
// Optional: define SRAM_FIFO_HWM_EN to add the hwm high-water-mark port.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sram_fifo_if.slave       strm,
  output logic             sram_csb,
  output logic             sram_web,
  output addr_t            sram_addr,
  output logic [WIDTH-1:0] sram_din,
  input  logic [WIDTH-1:0] sram_dout,
  output cnt_t             count
`ifdef SRAM_FIFO_HWM_EN
  ,
  output cnt_t             hwm
`endif
);

  addr_t      wr_ptr_r;
  addr_t      rd_ptr_r;
  addr_t      addr_r;
  cnt_t       sram_cnt_r;
  cnt_t       sram_cnt_nxt_s;
  logic       inflight_r;
  logic       prio_r;
  logic [1:0] buf_cnt_s;
  logic [2:0] occ_s;
  logic       in_valid_s;
  logic       pop_s;
  logic       rd_want_s;
  logic       wr_room_s;
  acc_e       acc_s;

  // Reset also blocks any write so the port stays quiet while rst is high.
  assign in_valid_s = strm.in_valid & ~rst;
  assign pop_s      = strm.out_valid & strm.out_ready;
  // Buffer slots committed after this edge: buffered + returning - leaving.
  assign occ_s      = {1'b0, buf_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign rd_want_s  = (sram_cnt_r != '0) && (occ_s < 3'd2);
  assign wr_room_s  = (sram_cnt_r < cnt_t'(DEPTH));

  assign strm.in_ready = wr_room_s & ~(rd_want_s & prio_r) & ~rst;

  // Pick the single SRAM access for this cycle.
  always_comb begin
    acc_s = ACC_IDLE;
    if (rd_want_s && (prio_r || !wr_room_s || !in_valid_s)) begin
      acc_s = ACC_READ;
    end else if (in_valid_s && wr_room_s) begin
      acc_s = ACC_WRITE;
    end else begin
      acc_s = ACC_IDLE;
    end
  end

  // Drive the SRAM port from the chosen access; idle holds the last address.
  always_comb begin
    sram_csb       = 1'b1;
    sram_web       = 1'b1;
    sram_addr      = addr_r;
    sram_cnt_nxt_s = sram_cnt_r;
    case (acc_s)
      ACC_WRITE: begin
        sram_csb       = 1'b0;
        sram_web       = 1'b0;
        sram_addr      = wr_ptr_r;
        sram_cnt_nxt_s = sram_cnt_r + cnt_t'(1);
      end
      ACC_READ: begin
        sram_csb       = 1'b0;
        sram_web       = 1'b1;
        sram_addr      = rd_ptr_r;
        sram_cnt_nxt_s = sram_cnt_r - cnt_t'(1);
      end
      default: begin
        sram_csb       = 1'b1;
        sram_web       = 1'b1;
        sram_addr      = addr_r;
        sram_cnt_nxt_s = sram_cnt_r;
      end
    endcase
  end

  assign sram_din = strm.in_data;

  // Pointers, SRAM occupancy, read-in-flight flag and arbitration priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      addr_r     <= '0;
      sram_cnt_r <= '0;
      inflight_r <= 1'b0;
      prio_r     <= 1'b0;
    end else begin
      if (acc_s == ACC_WRITE) begin
        wr_ptr_r <= wrap_inc(wr_ptr_r);
      end
      if (acc_s == ACC_READ) begin
        rd_ptr_r <= wrap_inc(rd_ptr_r);
      end
      addr_r     <= sram_addr;
      sram_cnt_r <= sram_cnt_nxt_s;
      inflight_r <= (acc_s == ACC_READ);
      // Only a true read/write conflict flips priority.
      if (rd_want_s && in_valid_s && wr_room_s) begin
        prio_r <= ~prio_r;
      end
    end
  end

  sram_fifo_outbuf u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (sram_dout),
    .pop       (pop_s),
    .cnt       (buf_cnt_s),
    .head      (strm.out_data)
  );

  assign strm.out_valid = (buf_cnt_s != 2'd0);
  assign count = sram_cnt_r + cnt_t'(inflight_r) + cnt_t'(buf_cnt_s);

`ifdef SRAM_FIFO_HWM_EN
  cnt_t hwm_r;
  cnt_t count_nxt_s;

  // occ_s is exactly next cycle's buffer fill; a read issued now is next in flight.
  assign count_nxt_s = sram_cnt_nxt_s + cnt_t'(acc_s == ACC_READ) + cnt_t'(occ_s);

  // Track the peak occupancy seen since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm_r <= '0;
    end else if (count_nxt_s > hwm_r) begin
      hwm_r <= count_nxt_s;
    end else begin
      hwm_r <= hwm_r;
    end
  end

  assign hwm = hwm_r;
`endif

endmodule
